// File: rtl/wbq_pkg.sv
// Shared types and constants for the register-bank write-back queue.
package wbq_pkg;

  localparam int REG_COUNT = 32;
  localparam int WB_ADDR_W = 5;
  localparam int WB_DATA_W = 64;

  localparam logic [WB_ADDR_W-1:0] XZR_ADDR = 5'd31;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wbq_fwd_match.sv
// Youngest-match search over the pending write-back entries for one read port.
module wbq_fwd_match
  import wbq_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter bit DROP_XZR = 1'b1,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  wb_entry_t              entries [DEPTH],
  input  logic [PTR_W-1:0]       head,
  input  logic [CNT_W-1:0]       count,
  input  logic [WB_ADDR_W-1:0]   addr,
  output logic                   hit,
  output logic [WB_DATA_W-1:0]   data
);

  logic                 scan_hit_s;
  logic [WB_DATA_W-1:0] scan_data_s;
  logic                 xzr_mask_s;

  // Walk oldest to youngest so the last valid match (the youngest) wins.
  always_comb begin
    scan_hit_s  = 1'b0;
    scan_data_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] idx;
      logic             match;
      idx         = head + PTR_W'(i);
      match       = (CNT_W'(i) < count) && (entries[idx].rd == addr);
      scan_hit_s  = scan_hit_s | match;
      scan_data_s = match ? entries[idx].data : scan_data_s;
    end
  end

  assign xzr_mask_s = DROP_XZR && (addr == XZR_ADDR);
  assign hit        = scan_hit_s & ~xzr_mask_s;
  assign data       = hit ? scan_data_s : {WB_DATA_W{1'b0}};

endmodule

// File: rtl/writeback_queue.sv
// In-order write-back queue in front of the register bank write port, with read forwarding.
// Optional statistics outputs are enabled by defining WBQ_STATS_EN.
module writeback_queue
  import wbq_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter bit DROP_XZR = 1'b1,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              fwd_hit1,
  output logic [DATA_W-1:0] fwd_data1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data2,
`ifdef WBQ_STATS_EN
  output logic [31:0]       stat_writes,
  output logic [31:0]       stat_stalls,
  output logic [CNT_W-1:0]  stat_peak,
`endif
  output logic              empty,
  output logic              full
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  wb_entry_t            entries_r [DEPTH];
  logic [PTR_W-1:0]     head_r;
  logic [PTR_W-1:0]     tail_r;
  logic [CNT_W-1:0]     count_r;

  logic                 pop_s;
  logic [CNT_W-1:0]     free_s;
  logic                 alu_push_s;
  logic                 mem_push_s;
  logic [1:0]           enq_s;
  logic [PTR_W-1:0]     mem_slot_s;
  logic [CNT_W-1:0]     count_next_s;
  logic [WB_DATA_W-1:0] fwd_raw1_s;
  logic [WB_DATA_W-1:0] fwd_raw2_s;

  // A pop frees its slot in the same cycle, so it counts toward free space.
  assign pop_s  = (count_r != {CNT_W{1'b0}});
  assign free_s = DEPTH_C - count_r + CNT_W'(pop_s);

  assign alu_ready = (free_s >= CNT_W'(1));
  assign mem_ready = alu_valid ? (free_s >= CNT_W'(2)) : (free_s >= CNT_W'(1));

  // Writes to the zero register still handshake but never occupy a slot.
  assign alu_push_s = alu_valid && alu_ready && !(DROP_XZR && (alu_rd == ADDR_W'(XZR_ADDR)));
  assign mem_push_s = mem_valid && mem_ready && !(DROP_XZR && (mem_rd == ADDR_W'(XZR_ADDR)));

  assign enq_s        = {1'b0, alu_push_s} + {1'b0, mem_push_s};
  assign mem_slot_s   = tail_r + PTR_W'(alu_push_s);
  assign count_next_s = count_r + CNT_W'(enq_s) - CNT_W'(pop_s);

  assign rf_write = pop_s;
  assign rf_addr  = ADDR_W'(entries_r[head_r].rd);
  assign rf_data  = DATA_W'(entries_r[head_r].data);
  assign empty    = (count_r == {CNT_W{1'b0}});
  assign full     = (count_r == DEPTH_C);

  // Pointer and occupancy state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      head_r  <= head_r + PTR_W'(pop_s);
      tail_r  <= tail_r + PTR_W'(enq_s);
      count_r <= count_next_s;
    end
  end

  // Entry storage; contents are don't-care until occupied, so no reset.
  always_ff @(posedge clock) begin
    if (alu_push_s) begin
      entries_r[tail_r] <= '{rd: WB_ADDR_W'(alu_rd), data: WB_DATA_W'(alu_data)};
    end
    if (mem_push_s) begin
      entries_r[mem_slot_s] <= '{rd: WB_ADDR_W'(mem_rd), data: WB_DATA_W'(mem_data)};
    end
  end

  wbq_fwd_match #(.DEPTH(DEPTH), .DROP_XZR(DROP_XZR)) u_fwd1 (
    .entries (entries_r),
    .head    (head_r),
    .count   (count_r),
    .addr    (WB_ADDR_W'(rd_addr1)),
    .hit     (fwd_hit1),
    .data    (fwd_raw1_s)
  );

  wbq_fwd_match #(.DEPTH(DEPTH), .DROP_XZR(DROP_XZR)) u_fwd2 (
    .entries (entries_r),
    .head    (head_r),
    .count   (count_r),
    .addr    (WB_ADDR_W'(rd_addr2)),
    .hit     (fwd_hit2),
    .data    (fwd_raw2_s)
  );

  assign fwd_data1 = DATA_W'(fwd_raw1_s);
  assign fwd_data2 = DATA_W'(fwd_raw2_s);

`ifdef WBQ_STATS_EN
  logic [31:0]      stat_writes_r;
  logic [31:0]      stat_stalls_r;
  logic [CNT_W-1:0] stat_peak_r;
  logic             stall_s;

  assign stall_s = (alu_valid && !alu_ready) || (mem_valid && !mem_ready);

  // Saturating activity counters and occupancy high-water mark.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_writes_r <= 32'd0;
      stat_stalls_r <= 32'd0;
      stat_peak_r   <= '0;
    end else begin
      if (pop_s && (stat_writes_r != 32'hFFFF_FFFF)) begin
        stat_writes_r <= stat_writes_r + 32'd1;
      end
      if (stall_s && (stat_stalls_r != 32'hFFFF_FFFF)) begin
        stat_stalls_r <= stat_stalls_r + 32'd1;
      end
      if (count_next_s > stat_peak_r) begin
        stat_peak_r <= count_next_s;
      end
    end
  end

  assign stat_writes = stat_writes_r;
  assign stat_stalls = stat_stalls_r;
  assign stat_peak   = stat_peak_r;
`endif

endmodule
